// File: rtl/ring_seq_pkg.sv
// Shared types and constants for the ring/Johnson step sequencer.
// Holds the sequencing mode enum and the seven-segment glyph table.
package ring_seq_pkg;

    typedef enum logic {
        RING    = 1'b0,
        JOHNSON = 1'b1
    } mode_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment order is {g,f,e,d,c,b,a}; dp is appended by the decoder.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] hex_glyph(
        input logic [3:0] hex,
        input logic       dp
    );
        return {dp, SEG_GLYPH[hex]};
    endfunction

endpackage

// File: rtl/ring_sequencer_seg7.sv
// Hex digit to seven-segment decoder for the sequencer step index.
// Blanks the whole display, dp included, while the pattern is invalid.
module seg7_hex_decoder
    import ring_seq_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       valid,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (valid) begin
            seg = hex_glyph(hex, dp);
        end
    end

endmodule

// File: rtl/ring_sequencer.sv
// One-hot / Johnson step sequencer with load, enable, direction and self-correction.
// Define RING_SEQ_SEG_EN to build the seven-segment hex decoder on seg.
module ring_sequencer
    import ring_seq_pkg::*;
#(
    parameter  int NBITS = 4,
    localparam int POS_W = $clog2(2 * NBITS)
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [NBITS-1:0] load_value,
    output logic [NBITS-1:0] count,
    output logic [POS_W-1:0] pos,
    output logic             valid,
    output logic             wrap,
    output logic [7:0]       seg
);

    localparam logic [NBITS-1:0] LSB_ONLY = NBITS'(1);
    localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [POS_W-1:0] N_POS    = POS_W'(NBITS);

    mode_t            md;
    logic [POS_W-1:0] ones;
    logic [POS_W-1:0] edges;
    logic [POS_W-1:0] ring_idx;
    logic [POS_W-1:0] john_pos;
    logic             ring_ok;
    logic             john_ok;
    logic [NBITS-1:0] step;
    logic             wrap_hit;

    assign md = mode_t'(mode);

    always_comb begin
        ones     = '0;
        edges    = '0;
        ring_idx = '0;
        for (int i = 0; i < NBITS; i++) begin
            ones = ones + POS_W'(count[i]);
            if (count[i]) begin
                ring_idx = POS_W'(i);
            end
        end
        for (int i = 0; i < NBITS - 1; i++) begin
            edges = edges + POS_W'(count[i] ^ count[i+1]);
        end
    end

    assign ring_ok = (ones == POS_W'(1));
    assign john_ok = (edges <= POS_W'(1));
    assign valid   = (md == JOHNSON) ? john_ok : ring_ok;

    // Upper half of the Johnson cycle counts the zeros shifted in after all-ones.
    assign john_pos = count[NBITS-1] ? (N_POS + (N_POS - ones)) : ones;

    always_comb begin
        pos = '0;
        if (valid) begin
            pos = (md == JOHNSON) ? john_pos : ring_idx;
        end
    end

    always_comb begin
        step     = '0;
        wrap_hit = 1'b0;
        if (!valid) begin
            if (md == RING) begin
                step = dir ? MSB_ONLY : LSB_ONLY;
            end
        end else if (md == RING) begin
            if (dir) begin
                step     = {count[0], count[NBITS-1:1]};
                wrap_hit = count[0];
            end else begin
                step     = {count[NBITS-2:0], count[NBITS-1]};
                wrap_hit = count[NBITS-1];
            end
        end else begin
            if (dir) begin
                step     = {~count[0], count[NBITS-1:1]};
                wrap_hit = (count == '0);
            end else begin
                step     = {count[NBITS-2:0], ~count[NBITS-1]};
                wrap_hit = (count == MSB_ONLY);
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step;
            wrap  <= wrap_hit;
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef RING_SEQ_SEG_EN
    logic [3:0] hex;

    assign hex = 4'(pos);

    seg7_hex_decoder u_seg (
        .hex   (hex),
        .valid (valid),
        .dp    (dir),
        .seg   (seg)
    );
`else
    assign seg = SEG_BLANK;
`endif

endmodule
